// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
package mem_arb_pkg;

   localparam int unsigned ADDR_W  = 9;
   localparam int unsigned DATA_W  = 32;
   localparam int unsigned FUNC3_W = 3;

   // Word-size code presented to memory for every instruction fetch.
   localparam logic [FUNC3_W-1:0] FETCH_FUNC3 = 3'b010;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_ACCESS,
      ARB_RESP
   } arb_state_e;

   typedef enum logic {
      OWN_INST,
      OWN_DATA
   } arb_owner_e;

   // Command latched at grant and held on the memory bus for the whole access.
   typedef struct packed {
      logic               we;
      logic [ADDR_W-1:0]  addr;
      logic [DATA_W-1:0]  wdata;
      logic [FUNC3_W-1:0] func3;
   } mem_cmd_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner select between fetch and data ports, with a saturating streak
// counter that bounds how many data grants a waiting fetch can lose to.
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   pick_en_i        arbiter is idle and may grant this cycle
//   inst_req_i       fetch request
//   inst_flush_i     fetch is stale this cycle (not eligible)
//   data_req_i       load/store request
//   gnt_valid_c_o    a grant happens this cycle (combinational)
//   gnt_data_c_o     grant goes to the data port (combinational)
module mem_arb_pick #(
   parameter int unsigned MAX_DSTREAK = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic pick_en_i,
   input  logic inst_req_i,
   input  logic inst_flush_i,
   input  logic data_req_i,
   output logic gnt_valid_c_o,
   output logic gnt_data_c_o
);

   localparam int unsigned STREAK_W = $clog2(MAX_DSTREAK + 1);

   logic [STREAK_W-1:0] streak_q, streak_d;
   logic                inst_elig;
   logic                streak_max;

   assign inst_elig  = inst_req_i & ~inst_flush_i;
   assign streak_max = (streak_q == STREAK_W'(MAX_DSTREAK));

   // Data wins ties until the waiting fetch has lost MAX_DSTREAK times in a row.
   assign gnt_data_c_o  = data_req_i & ~(inst_elig & streak_max);
   assign gnt_valid_c_o = pick_en_i & (data_req_i | inst_elig);

   // Streak counts data grants taken while a fetch was requesting.
   always_comb begin
      streak_d = streak_q;
      if (gnt_valid_c_o) begin
         if (gnt_data_c_o && inst_req_i) begin
            if (!streak_max) begin
               streak_d = streak_q + STREAK_W'(1);
            end
         end else begin
            streak_d = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         streak_q <= '0;
      end else begin
         streak_q <= streak_d;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and data access.
// One transaction at a time: issue, fixed-latency wait, one-cycle response.
// Ports:
//   clk, reset                        clock, synchronous active-high reset
//   inst_req/addr/flush -> inst_done/rdata/stall    fetch port
//   data_req/we/addr/wdata/func3 -> data_done/rdata/stall   load/store port
//   gnt_data                          current owner is the data port
//   mem_en/we/addr/wdata/func3, mem_rdata           memory interface
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned MEM_LAT     = 1,
   parameter int unsigned MAX_DSTREAK = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               inst_req,
   input  logic [ADDR_W-1:0]  inst_addr,
   input  logic               inst_flush,
   output logic               inst_done,
   output logic [DATA_W-1:0]  inst_rdata,
   output logic               inst_stall,
   input  logic               data_req,
   input  logic               data_we,
   input  logic [ADDR_W-1:0]  data_addr,
   input  logic [DATA_W-1:0]  data_wdata,
   input  logic [FUNC3_W-1:0] data_func3,
   output logic               data_done,
   output logic [DATA_W-1:0]  data_rdata,
   output logic               data_stall,
   output logic               gnt_data,
   output logic               mem_en,
   output logic               mem_we,
   output logic [ADDR_W-1:0]  mem_addr,
   output logic [DATA_W-1:0]  mem_wdata,
   output logic [FUNC3_W-1:0] mem_func3,
   input  logic [DATA_W-1:0]  mem_rdata
);

   localparam int unsigned CNT_W = $clog2(MEM_LAT + 1);

   arb_state_e         state_q, state_d;
   arb_owner_e         owner_q, owner_d;
   mem_cmd_t           cmd_q, cmd_d;
   logic               mem_en_q, mem_en_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               flush_pend_q, flush_pend_d;
   logic               inst_done_q, inst_done_d;
   logic               data_done_q, data_done_d;
   logic [DATA_W-1:0]  inst_rdata_q, inst_rdata_d;
   logic [DATA_W-1:0]  data_rdata_q, data_rdata_d;
   logic               gnt_valid_c;
   logic               gnt_data_c;

   mem_arb_pick #(
      .MAX_DSTREAK (MAX_DSTREAK)
   ) u_pick (
      .clk           (clk),
      .reset         (reset),
      .pick_en_i     (state_q == ARB_IDLE),
      .inst_req_i    (inst_req),
      .inst_flush_i  (inst_flush),
      .data_req_i    (data_req),
      .gnt_valid_c_o (gnt_valid_c),
      .gnt_data_c_o  (gnt_data_c)
   );

   // Next-state, command latch, and response generation.
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      cmd_d        = cmd_q;
      mem_en_d     = 1'b0;
      cnt_d        = cnt_q;
      flush_pend_d = flush_pend_q;
      inst_done_d  = 1'b0;
      data_done_d  = 1'b0;
      inst_rdata_d = inst_rdata_q;
      data_rdata_d = data_rdata_q;

      case (state_q)
         ARB_IDLE: begin
            flush_pend_d = 1'b0;
            if (gnt_valid_c) begin
               if (gnt_data_c) begin
                  owner_d     = OWN_DATA;
                  cmd_d.we    = data_we;
                  cmd_d.addr  = data_addr;
                  cmd_d.wdata = data_wdata;
                  cmd_d.func3 = data_func3;
               end else begin
                  owner_d     = OWN_INST;
                  cmd_d.we    = 1'b0;
                  cmd_d.addr  = inst_addr;
                  cmd_d.wdata = '0;
                  cmd_d.func3 = FETCH_FUNC3;
               end
               mem_en_d = 1'b1;
               cnt_d    = CNT_W'(MEM_LAT);
               state_d  = ARB_ACCESS;
            end
         end

         ARB_ACCESS: begin
            if (owner_q == OWN_INST && inst_flush) begin
               flush_pend_d = 1'b1;
            end
            // cnt reaches zero on the cycle mem_rdata is valid.
            if (cnt_q == '0) begin
               state_d = ARB_RESP;
               if (owner_q == OWN_DATA) begin
                  data_done_d = 1'b1;
                  if (!cmd_q.we) begin
                     data_rdata_d = mem_rdata;
                  end
               end else if (!(flush_pend_q || inst_flush)) begin
                  inst_done_d  = 1'b1;
                  inst_rdata_d = mem_rdata;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end

         ARB_RESP: begin
            flush_pend_d = 1'b0;
            state_d      = ARB_IDLE;
         end

         default: begin
            state_d = ARB_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ARB_IDLE;
         owner_q      <= OWN_INST;
         cmd_q        <= '0;
         mem_en_q     <= 1'b0;
         cnt_q        <= '0;
         flush_pend_q <= 1'b0;
         inst_done_q  <= 1'b0;
         data_done_q  <= 1'b0;
         inst_rdata_q <= '0;
         data_rdata_q <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         cmd_q        <= cmd_d;
         mem_en_q     <= mem_en_d;
         cnt_q        <= cnt_d;
         flush_pend_q <= flush_pend_d;
         inst_done_q  <= inst_done_d;
         data_done_q  <= data_done_d;
         inst_rdata_q <= inst_rdata_d;
         data_rdata_q <= data_rdata_d;
      end
   end

   assign inst_done  = inst_done_q;
   assign inst_rdata = inst_rdata_q;
   assign data_done  = data_done_q;
   assign data_rdata = data_rdata_q;
   assign gnt_data   = (owner_q == OWN_DATA);
   assign mem_en     = mem_en_q;
   assign mem_we     = cmd_q.we;
   assign mem_addr   = cmd_q.addr;
   assign mem_wdata  = cmd_q.wdata;
   assign mem_func3  = cmd_q.func3;

   // Stalls follow the requests directly so the pipeline freezes the same cycle.
   assign inst_stall = inst_req & ~inst_done_q;
   assign data_stall = data_req & ~data_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter (MEM_LAT=2, MAX_DSTREAK=4).
module tb_mem_port_arbiter;

   localparam int unsigned LAT  = 2;
   localparam int          MAXD = 4;
   localparam int          NCYC = 4000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        inst_req = 1'b0, inst_flush = 1'b0;
   logic [8:0]  inst_addr = '0;
   logic        inst_done, inst_stall;
   logic [31:0] inst_rdata;
   logic        data_req = 1'b0, data_we = 1'b0;
   logic [8:0]  data_addr = '0;
   logic [31:0] data_wdata = '0;
   logic [2:0]  data_func3 = '0;
   logic        data_done, data_stall, gnt_data;
   logic [31:0] data_rdata;
   logic        mem_en, mem_we;
   logic [8:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [2:0]  mem_func3;
   logic [31:0] mem_rdata = '0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.MEM_LAT(LAT), .MAX_DSTREAK(MAXD)) dut (
      .clk(clk), .reset(reset),
      .inst_req(inst_req), .inst_addr(inst_addr), .inst_flush(inst_flush),
      .inst_done(inst_done), .inst_rdata(inst_rdata), .inst_stall(inst_stall),
      .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
      .data_wdata(data_wdata), .data_func3(data_func3),
      .data_done(data_done), .data_rdata(data_rdata), .data_stall(data_stall),
      .gnt_data(gnt_data),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_func3(mem_func3), .mem_rdata(mem_rdata)
   );

   typedef struct {
      int          cyc;
      bit          is_data;
      bit          we;
      logic [8:0]  addr;
      logic [31:0] wdata;
      logic [2:0]  func3;
   } cmd_exp_t;

   typedef struct {
      int          cyc;
      bit          is_data;
      logic [31:0] rdata;
   } done_exp_t;

   cmd_exp_t    cmdq[$];
   done_exp_t   doneq[$];
   int          n_vec = 0, n_err = 0;
   int          cyc = 0;
   int          rst_chk = -1;
   logic [31:0] ref_mem [128];
   logic [31:0] bus_mem [128];

   function automatic logic [31:0] init_word(int i);
      return 32'h0100_0000 ^ (32'(i) * 32'h0003_0507);
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @cyc %0d: got %h, want %h", name, cyc, act, exp);
      end
   endtask

   // Reference model: transaction timeline from the arbitration rules.
   // A grant decided at edge e occupies edges e+1..e+2+LAT; the response
   // is due in cycle e+2+LAT; flushes seen on edges e+1..e+1+LAT kill a fetch.
   bit          busy = 0, cur_data = 0, cur_we = 0, cur_kill = 0;
   int          cur_e = 0, streak = 0;
   logic [31:0] cur_rdata, model_dreg = '0;

   always @(posedge clk) begin : model
      bit       ie, de;
      cmd_exp_t c;
      if (reset) begin
         cmdq.delete();
         doneq.delete();
         busy       = 0;
         streak     = 0;
         model_dreg = '0;
         rst_chk    = cyc + 1;
      end else if (busy) begin
         if (!cur_data && inst_flush && cyc <= cur_e + 1 + int'(LAT)) cur_kill = 1;
         if (cyc == cur_e + 1 + int'(LAT)) begin
            if (cur_data) begin
               if (!cur_we) model_dreg = cur_rdata;
               doneq.push_back('{cyc + 1, 1'b1, model_dreg});
            end else if (!cur_kill) begin
               doneq.push_back('{cyc + 1, 1'b0, cur_rdata});
            end
         end
         if (cyc == cur_e + 2 + int'(LAT)) busy = 0;
      end else begin
         ie = inst_req && !inst_flush;
         de = data_req;
         if (ie || de) begin
            cur_data = de && !(ie && streak == MAXD);
            if (cur_data && inst_req) streak = (streak < MAXD) ? streak + 1 : streak;
            else streak = 0;
            c.cyc     = cyc + 1;
            c.is_data = cur_data;
            c.we      = cur_data ? data_we : 1'b0;
            c.addr    = cur_data ? data_addr : inst_addr;
            c.wdata   = data_wdata;
            c.func3   = cur_data ? data_func3 : 3'b010;
            cur_we    = c.we;
            cur_rdata = ref_mem[c.addr[8:2]];
            if (c.we) ref_mem[c.addr[8:2]] = c.wdata;
            cmdq.push_back(c);
            busy     = 1;
            cur_e    = cyc;
            cur_kill = 0;
         end
      end
      cyc = cyc + 1;
   end

   // Memory responder: valid data exactly LAT cycles after mem_en, noise otherwise.
   int          rsp_cyc = -1;
   logic [31:0] rsp_data = '0;
   always @(posedge clk) begin : responder
      #2;
      if (mem_en === 1'b1) begin
         rsp_cyc  = cyc + int'(LAT);
         rsp_data = bus_mem[mem_addr[8:2]];
         if (mem_we) bus_mem[mem_addr[8:2]] = mem_wdata;
      end
      mem_rdata = (cyc == rsp_cyc) ? rsp_data : $urandom();
   end

   // Monitor: compares DUT outputs against queued expectations each cycle.
   logic [31:0] mon_ireg = '0, mon_dreg = '0;
   always @(negedge clk) begin : monitor
      bit        exp_men, exp_id, exp_dd;
      cmd_exp_t  c;
      done_exp_t d;
      if (cyc >= 1) begin
         if (cyc == rst_chk) begin
            mon_ireg = '0;
            mon_dreg = '0;
            check("rst_mem_we", 32'(mem_we), 32'd0);
            check("rst_mem_addr", 32'(mem_addr), 32'd0);
            check("rst_mem_wdata", mem_wdata, 32'd0);
            check("rst_mem_func3", 32'(mem_func3), 32'd0);
            check("rst_gnt_data", 32'(gnt_data), 32'd0);
         end
         exp_men = cmdq.size() > 0 && cmdq[0].cyc == cyc;
         check("mem_en", 32'(mem_en), 32'(exp_men));
         if (exp_men) begin
            c = cmdq.pop_front();
            check("gnt_data", 32'(gnt_data), 32'(c.is_data));
            check("mem_we", 32'(mem_we), 32'(c.we));
            check("mem_addr", 32'(mem_addr), 32'(c.addr));
            check("mem_func3", 32'(mem_func3), 32'(c.func3));
            if (c.we) check("mem_wdata", mem_wdata, c.wdata);
         end
         exp_id = doneq.size() > 0 && doneq[0].cyc == cyc && !doneq[0].is_data;
         exp_dd = doneq.size() > 0 && doneq[0].cyc == cyc && doneq[0].is_data;
         check("inst_done", 32'(inst_done), 32'(exp_id));
         check("data_done", 32'(data_done), 32'(exp_dd));
         check("inst_stall", 32'(inst_stall), 32'(inst_req && !exp_id));
         check("data_stall", 32'(data_stall), 32'(data_req && !exp_dd));
         if (exp_id || exp_dd) begin
            d = doneq.pop_front();
            if (d.is_data) mon_dreg = d.rdata;
            else mon_ireg = d.rdata;
         end
         check("inst_rdata", inst_rdata, mon_ireg);
         check("data_rdata", data_rdata, mon_dreg);
      end
   end

   task automatic new_data();
      data_we    = 1'($urandom());
      data_addr  = 9'($urandom());
      data_wdata = $urandom();
      data_func3 = 3'($urandom());
   endtask

   // Stimulus: randomized requesters obeying hold-until-done, with flushes,
   // occasional resets, and alternating light/heavy load phases.
   initial begin
      bit hi;
      for (int i = 0; i < 128; i++) begin
         ref_mem[i] = init_word(i);
         bus_mem[i] = init_word(i);
      end
      repeat (3) @(posedge clk);
      for (int k = 0; k < NCYC; k++) begin
         @(posedge clk);
         #2;
         hi    = ((k / 200) % 2) == 1;
         reset = (k % 700) == 350;
         if (inst_req && inst_done) begin
            inst_req  = hi || ($urandom() % 3 != 0);
            inst_addr = 9'($urandom()) & 9'h1FC;
         end else if (!inst_req && (hi || $urandom() % 3 == 0)) begin
            inst_req  = 1'b1;
            inst_addr = 9'($urandom()) & 9'h1FC;
         end
         inst_flush = ($urandom() % 12) == 0;
         if (inst_flush) inst_addr = 9'($urandom()) & 9'h1FC;
         if (data_req && data_done) begin
            data_req = hi || ($urandom() % 3 != 0);
            new_data();
         end else if (!data_req && (hi || $urandom() % 3 == 0)) begin
            data_req = 1'b1;
            new_data();
         end
      end
      @(posedge clk);
      #2;
      inst_req   = 1'b0;
      data_req   = 1'b0;
      inst_flush = 1'b0;
      reset      = 1'b0;
      repeat (20) @(posedge clk);
      @(negedge clk);
      #1;
      check("drain_cmd", 32'(cmdq.size()), 32'd0);
      check("drain_done", 32'(doneq.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
